// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit, sub-word stores via read-modify-write; define MISALIGN_TRAP_EN to flag misaligned/illegal accesses
module dmem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] load_data,
  output logic              lsu_stall,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {IDLE, MERGE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] merge, merge_n, rep, shifted, ext;
  logic [ADDR_W-1:0] adr_q;
  logic [1:0] sz;
  logic [3:0] be;
  logic [4:0] sh;
  logic illegal, bad, active, go;
  assign illegal = (req_funct3 == 3'b011) | (req_funct3[2] & req_funct3[1]);
`ifdef MISALIGN_TRAP_EN
  assign sz = req_funct3[1:0];
  assign bad = illegal | (sz == 2'b01 & req_addr[0]) | (sz == 2'b10 & |req_addr[1:0]);
`else
  assign sz = illegal ? 2'b10 : req_funct3[1:0];
  assign bad = 1'b0;
`endif
  assign active = ~rst & req_valid & (state == IDLE);
  assign go = active & ~bad;
  // lane selection, load extension, byte-lane merge and memory port drive
  always_comb begin
    be = sz == 2'b00 ? 4'b0001 << req_addr[1:0] : sz == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rep = sz == 2'b00 ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};
    merge_n = mem_rdata;
    for (int i = 0; i < 4; i++) merge_n[8*i +: 8] = be[i] ? rep[8*i +: 8] : mem_rdata[8*i +: 8];
    sh = sz == 2'b00 ? {req_addr[1:0], 3'b000} : {req_addr[1], 4'b0000};
    shifted = mem_rdata >> sh;
    ext = sz == 2'b00 ? {{24{~req_funct3[2] & shifted[7]}}, shifted[7:0]}
        : sz == 2'b01 ? {{16{~req_funct3[2] & shifted[15]}}, shifted[15:0]} : mem_rdata;
    load_data = (go & ~req_we) ? ext : '0;
    misalign = active & bad;
    lsu_stall = go & req_we & (sz != 2'b10);
    mem_we = ~rst & ((state == MERGE) | (go & req_we & (sz == 2'b10)));
    mem_adr = state == MERGE ? adr_q : {req_addr[ADDR_W-1:2], 2'b00};
    mem_wdata = state == MERGE ? merge : req_wdata;
    state_n = lsu_stall ? MERGE : IDLE;
  end
  // state register plus merged word and word address held for the write cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      merge <= '0;
      adr_q <= '0;
    end else begin
      state <= state_n;
      if (lsu_stall) begin
        merge <= merge_n;
        adr_q <= mem_adr;
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random load/store checks against an array-based memory reference model
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst, req_valid, req_we, lsu_stall, misalign, mem_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, load_data, mem_adr, mem_wdata, mem_rdata, obs_ld;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  dmem_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .load_data(load_data), .lsu_stall(lsu_stall),
    .misalign(misalign), .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  assign mem_rdata = mem[mem_adr[9:2]];
  // word-wide memory with asynchronous read
  always @(posedge clk) if (mem_we) mem[mem_adr[9:2]] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom_range(0, 1023);
    #1;
    chk("idle_we", mem_we, 0);
    chk("idle_ld", load_data, 0);
    chk("idle_stall", lsu_stall, 0);
    chk("idle_adr", mem_adr, req_addr & ~32'h3);
  endtask
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int o, sz;
    logic illegal, bad;
    logic [31:0] w, v, ld, mask, nw;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    w = ref_mem[a[9:2]];
    o = int'(a[1:0]);
    illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    sz = illegal ? 4 : 1 << f3[1:0];
`ifdef MISALIGN_TRAP_EN
    bad = illegal || (o % sz != 0);
`else
    bad = 1'b0;
`endif
    o = o - o % sz;
    v = w >> (8 * o);
    ld = sz == 4 ? v : sz == 2 ? (f3[2] ? v & 32'hFFFF : 32'($signed(v[15:0])))
       : (f3[2] ? v & 32'hFF : 32'($signed(v[7:0])));
    #1;
    obs_ld = load_data;
    chk("load_data", load_data, (!we && !bad) ? ld : 32'h0);
    chk("misalign", misalign, bad);
    chk("mem_adr", mem_adr, a & ~32'h3);
    chk("mem_we", mem_we, we && !bad && sz == 4);
    chk("lsu_stall", lsu_stall, we && !bad && sz < 4);
    if (we && !bad) begin
      mask = sz == 4 ? 32'hFFFFFFFF : ((sz == 1 ? 32'hFF : 32'hFFFF) << (8 * o));
      nw = (w & ~mask) | ((d << (8 * o)) & mask);
      ref_mem[a[9:2]] = nw;
      if (sz == 4) chk("mem_wdata", mem_wdata, nw);
      else begin
        @(negedge clk);
        #1;
        chk("merge_we", mem_we, 1);
        chk("merge_adr", mem_adr, a & ~32'h3);
        chk("merge_wdata", mem_wdata, nw);
        chk("merge_stall", lsu_stall, 0);
      end
      @(posedge clk);
      #1;
      chk("mem_word", mem[a[9:2]], nw);
    end
  endtask
  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      mem[i] = r;
      ref_mem[i] = r;
    end
    mem[8'h40] = 32'h8899AABB;
    ref_mem[8'h40] = 32'h8899AABB;
    mem[8'hC0] = 32'hAABBCCDD;
    ref_mem[8'hC0] = 32'hAABBCCDD;
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h100;
    req_wdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_stall", lsu_stall, 0);
    chk("rst_mis", misalign, 0);
    req_we = 1'b0;
    #1;
    chk("rst_ld", load_data, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    req(0, 3'b000, 32'h101, 0);
    chk("t1_lb", obs_ld, 32'hFFFFFFAA);
    req(0, 3'b100, 32'h101, 0);
    chk("t1_lbu", obs_ld, 32'h000000AA);
    req(0, 3'b001, 32'h102, 0);
    chk("t1_lh", obs_ld, 32'hFFFF8899);
    req(0, 3'b101, 32'h102, 0);
    chk("t1_lhu", obs_ld, 32'h00008899);
    req(1, 3'b010, 32'h200, 32'h12345678);
    req(0, 3'b010, 32'h200, 0);
    chk("t2_lw", obs_ld, 32'h12345678);
    req(1, 3'b000, 32'h302, 32'hFFFFFF11);
    chk("t3_word", mem[8'hC0], 32'hAA11CCDD);
    req(1, 3'b001, 32'h300, 32'h1234BEEF);
    req(0, 3'b010, 32'h300, 0);
    chk("t4_lw", obs_ld, 32'hAA11BEEF);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b000;
    req_addr = 32'h304;
    req_wdata = 32'h55;
    #1;
    chk("t5_stall", lsu_stall, 1);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("t5_we", mem_we, 0);
    @(posedge clk);
    #1;
    chk("t5_word", mem[8'hC1], ref_mem[8'hC1]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_idle_we", mem_we, 0);
    chk("t5_idle_stall", lsu_stall, 0);
    req(1, 3'b010, 32'h201, 32'hCAFEF00D);
    req(0, 3'b010, 32'h200, 0);
    req(0, 3'b001, 32'h103, 0);
    req(0, 3'b011, 32'h100, 0);
    req(1, 3'b110, 32'h302, 32'h0BADF00D);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 1023), $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
